alu_exec_ctrl: RTL and testbench

//  Execute-stage controller around the 8-bit alu: accepts one packed instruction per handshake,

---
 rtl/alu_exec_ctrl_pkg.sv | 49 ++++
 rtl/alu_exec_ctrl_if.sv | 34 +++
 rtl/alu_exec_ctrl_alu.sv | 49 ++++
 rtl/alu_exec_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_ctrl_pkg
//  Brief    : Shared opcode encodings, FSM states and decode helpers for the
//             execute-stage controller and its alu.
//  Revision : 1.0  initial release
// ============================================================================
package alu_exec_ctrl_pkg;

  localparam int OP_W   = 4;
  localparam int ALU_DW = 8;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_INC = 4'b0010;
  localparam logic [OP_W-1:0] OP_DEC = 4'b0100;
  localparam logic [OP_W-1:0] OP_AND = 4'b1000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b1001;
  localparam logic [OP_W-1:0] OP_NOT = 4'b1010;
  localparam logic [OP_W-1:0] OP_XOR = 4'b1100;
  localparam logic [OP_W-1:0] OP_SL  = 4'b1110;
  localparam logic [OP_W-1:0] OP_SR  = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOP = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // True for every defined opcode, including NOP.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_AND, OP_OR,
      OP_NOT, OP_XOR, OP_SL,  OP_SR,  OP_NOP: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
    return legal;
  endfunction

  // True when the op commits a result to the register file and flags.
  function automatic logic op_writes_back(input logic [OP_W-1:0] op);
    return op_is_legal(op) && (op != OP_NOP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_ctrl_if
//  Brief    : Instruction handshake and completion bus between the upstream
//             instruction source (master) and the execute controller (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface alu_exec_ctrl_if
  import alu_exec_ctrl_pkg::*;
#(
  parameter int AW = 2,
  parameter int DW = 8
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [OP_W+2*AW-1:0]  in_instr;
  logic                  done;
  logic [DW-1:0]         done_result;
  logic                  illegal_op;
  logic                  busy;

  modport master (
    output in_valid, in_instr,
    input  in_ready, done, done_result, illegal_op, busy
  );

  modport slave (
    input  in_valid, in_instr,
    output in_ready, done, done_result, illegal_op, busy
  );

endinterface
`default_nettype wire

// File: rtl/alu_exec_ctrl_alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_ctrl_alu
//  Brief    : Combinational 8-bit alu. Carry is the adder carry-out for ADD
//             and the borrow for SUB; every other op reports carry 0.
//  Revision : 1.0  initial release
// ============================================================================
module alu_exec_ctrl_alu
  import alu_exec_ctrl_pkg::*;
(
  input  wire logic [ALU_DW-1:0] a_i,
  input  wire logic [ALU_DW-1:0] b_i,
  input  wire logic [OP_W-1:0]   op_i,
  output logic      [ALU_DW-1:0] result_o,
  output logic                   carry_o
);

  logic [ALU_DW:0] sum_w;

  // Op decode; shifts fill with zero, INC/DEC wrap without reporting carry.
  always_comb begin
    sum_w    = '0;
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD: begin
        sum_w    = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum_w[ALU_DW-1:0];
        carry_o  = sum_w[ALU_DW];
      end
      OP_SUB: begin
        sum_w    = {1'b0, a_i} - {1'b0, b_i};
        result_o = sum_w[ALU_DW-1:0];
        carry_o  = sum_w[ALU_DW];
      end
      OP_INC:  result_o = a_i + 8'd1;
      OP_DEC:  result_o = a_i - 8'd1;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_NOT:  result_o = ~a_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SL:   result_o = {a_i[ALU_DW-2:0], 1'b0};
      OP_SR:   result_o = {1'b0, a_i[ALU_DW-1:1]};
      default: result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_ctrl
//  Brief    : Non-pipelined execute-stage controller. Accepts one instruction
//             per handshake, reads operands from an inline register file,
//             runs them through the alu and writes the result back to rd,
//             updating carry/zero flags. FSM: IDLE -> EXEC -> WB -> IDLE.
//             rst_n is expected to be released synchronously to clk.
//  Revision : 1.0  initial release
// ============================================================================
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter  int NREGS = 4,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  alu_exec_ctrl_if.slave     up,
  input  wire logic          host_wr_en,
  input  wire logic [AW-1:0] host_wr_addr,
  input  wire logic [DW-1:0] host_wr_data,
  input  wire logic [AW-1:0] rd_addr,
  output logic      [DW-1:0] rd_data,
  output logic               carry_flag,
  output logic               zero_flag
);

  localparam int IW = OP_W + 2*AW;

  state_e           state_q, state_d;
  logic [IW-1:0]    instr_q;
  logic [DW-1:0]    regs_q [NREGS];
  logic [DW-1:0]    hold_res_q;
  logic             hold_carry_q;
  logic [DW-1:0]    done_result_q;
  logic             carry_q;
  logic             zero_q;

  logic [OP_W-1:0]  op_w;
  logic [AW-1:0]    rd_w;
  logic [AW-1:0]    rs_w;
  logic [DW-1:0]    alu_res_w;
  logic             alu_carry_w;
  logic             in_ready_w;
  logic             done_w;
  logic             illegal_w;
  logic             wb_en_w;

  assign op_w = instr_q[IW-1 -: OP_W];
  assign rd_w = instr_q[2*AW-1 -: AW];
  assign rs_w = instr_q[AW-1:0];

  alu_exec_ctrl_alu u_alu (
    .a_i      (regs_q[rd_w]),
    .b_i      (regs_q[rs_w]),
    .op_i     (op_w),
    .result_o (alu_res_w),
    .carry_o  (alu_carry_w)
  );

  // Next-state and per-state control decode.
  always_comb begin
    state_d    = state_q;
    in_ready_w = 1'b0;
    done_w     = 1'b0;
    illegal_w  = 1'b0;
    wb_en_w    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_w = 1'b1;
        if (up.in_valid) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        done_w    = 1'b1;
        illegal_w = ~op_is_legal(op_w);
        wb_en_w   = op_writes_back(op_w);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture the instruction on the accepting handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             instr_q <= '0;
    else if (in_ready_w && up.in_valid)     instr_q <= up.in_instr;
  end

  // Hold the alu outcome at the end of EXEC for use during WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_res_q   <= '0;
      hold_carry_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      hold_res_q   <= alu_res_w;
      hold_carry_q <= alu_carry_w;
    end
  end

  // Register file: host preload only while idle, result writeback in WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (in_ready_w && host_wr_en) begin
      regs_q[host_wr_addr] <= host_wr_data;
    end else if (wb_en_w) begin
      regs_q[rd_w] <= hold_res_q;
    end
  end

  // Flags and completed-result register, updated only by committing ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_result_q <= '0;
      carry_q       <= 1'b0;
      zero_q        <= 1'b0;
    end else if (wb_en_w) begin
      done_result_q <= hold_res_q;
      carry_q       <= hold_carry_q;
      zero_q        <= (hold_res_q == '0);
    end
  end

  // The new result is presented alongside done, then held from the register.
  assign up.done_result = wb_en_w ? hold_res_q : done_result_q;
  assign up.in_ready    = in_ready_w;
  assign up.busy        = ~in_ready_w;
  assign up.done        = done_w;
  assign up.illegal_op  = illegal_w;
  assign rd_data        = regs_q[rd_addr];
  assign carry_flag     = carry_q;
  assign zero_flag      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_ctrl
//  Brief    : Directed self-checking bench for alu_exec_ctrl with
//             hand-computed expected values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_wr_en = 1'b0;
  logic [1:0] host_wr_addr = '0;
  logic [7:0] host_wr_data = '0;
  logic [1:0] rd_addr = '0;
  wire  [7:0] rd_data;
  wire        carry_flag;
  wire        zero_flag;

  int checks = 0;
  int errors = 0;

  alu_exec_ctrl_if #(.AW(2), .DW(8)) up_if ();

  alu_exec_ctrl #(.NREGS(4), .DW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .up           (up_if),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .carry_flag   (carry_flag),
    .zero_flag    (zero_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic flag_chk(input string tag, input logic c, input logic z);
    chk({tag, "_carry"}, {31'd0, carry_flag}, {31'd0, c});
    chk({tag, "_zero"},  {31'd0, zero_flag},  {31'd0, z});
  endtask

  // Called at a negedge; leaves at the following negedge.
  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    host_wr_en   = 1'b1;
    host_wr_addr = a;
    host_wr_data = d;
    @(posedge clk);
    @(negedge clk);
    host_wr_en   = 1'b0;
  endtask

  // Full single transaction with cycle-exact timing checks. Called at a negedge
  // in IDLE; returns at the negedge after WB (back in IDLE).
  task automatic run_instr(input string tag, input logic [7:0] instr,
                           input logic [7:0] exp_res, input logic exp_ill);
    up_if.in_valid = 1'b1;
    up_if.in_instr = instr;
    @(posedge clk);
    @(negedge clk);
    up_if.in_valid = 1'b0;
    chk({tag, "_exec_ready"}, {31'd0, up_if.in_ready}, 32'd0);
    chk({tag, "_exec_done"},  {31'd0, up_if.done},     32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_wb_done"},    {31'd0, up_if.done},       32'd1);
    chk({tag, "_wb_busy"},    {31'd0, up_if.busy},       32'd1);
    chk({tag, "_wb_illegal"}, {31'd0, up_if.illegal_op}, {31'd0, exp_ill});
    chk({tag, "_wb_result"},  {24'd0, up_if.done_result}, {24'd0, exp_res});
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle_done"},    {31'd0, up_if.done},       32'd0);
    chk({tag, "_idle_ready"},   {31'd0, up_if.in_ready},   32'd1);
    chk({tag, "_idle_illegal"}, {31'd0, up_if.illegal_op}, 32'd0);
    chk({tag, "_held_result"},  {24'd0, up_if.done_result}, {24'd0, exp_res});
  endtask

  initial begin
    logic [7:0] b2b_instr [3];
    logic [7:0] b2b_res   [3];
    up_if.in_valid = 1'b0;
    up_if.in_instr = '0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready",   {31'd0, up_if.in_ready},   32'd1);
    chk("rst_busy",    {31'd0, up_if.busy},       32'd0);
    chk("rst_done",    {31'd0, up_if.done},       32'd0);
    chk("rst_illegal", {31'd0, up_if.illegal_op}, 32'd0);
    chk("rst_result",  {24'd0, up_if.done_result}, 32'd0);
    flag_chk("rst", 1'b0, 1'b0);
    rd_chk("rst_r0", 2'd0, 8'h00);
    rd_chk("rst_r3", 2'd3, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD r0=FF + r1=01 -> 00, carry 1, zero 1.
    host_write(2'd0, 8'hFF);
    host_write(2'd1, 8'h01);
    rd_chk("pre_r0", 2'd0, 8'hFF);
    run_instr("add", {4'b0000, 2'd0, 2'd1}, 8'h00, 1'b0);
    rd_chk("add_r0", 2'd0, 8'h00);
    rd_chk("add_r1", 2'd1, 8'h01);
    flag_chk("add", 1'b1, 1'b1);

    // SUB r2=00 - r3=01 -> FF, borrow 1, zero 0.
    host_write(2'd2, 8'h00);
    host_write(2'd3, 8'h01);
    run_instr("sub", {4'b0001, 2'd2, 2'd3}, 8'hFF, 1'b0);
    rd_chk("sub_r2", 2'd2, 8'hFF);
    flag_chk("sub", 1'b1, 1'b0);

    // ADD r3=01 + r2=FF -> 00, then illegal op 0011 changes nothing.
    run_instr("add2", {4'b0000, 2'd3, 2'd2}, 8'h00, 1'b0);
    flag_chk("add2", 1'b1, 1'b1);
    host_write(2'd3, 8'h5A);
    run_instr("ill", {4'b0011, 2'd3, 2'd2}, 8'h00, 1'b1);
    rd_chk("ill_r3", 2'd3, 8'h5A);
    rd_chk("ill_r2", 2'd2, 8'hFF);
    flag_chk("ill", 1'b1, 1'b1);

    // NOP: no register, flag or result update.
    run_instr("nop", {4'b0110, 2'd3, 2'd3}, 8'h00, 1'b0);
    rd_chk("nop_r3", 2'd3, 8'h5A);
    flag_chk("nop", 1'b1, 1'b1);
    host_write(2'd3, 8'h00);

    // Back-to-back with in_valid held high: r0=00 r1=01 r2=FF r3=00.
    b2b_instr[0] = {4'b0010, 2'd0, 2'd0};  b2b_res[0] = 8'h01; // INC r0
    b2b_instr[1] = {4'b1110, 2'd1, 2'd0};  b2b_res[1] = 8'h02; // SL r1
    b2b_instr[2] = {4'b1001, 2'd3, 2'd2};  b2b_res[2] = 8'hFF; // OR r3|r2
    up_if.in_valid = 1'b1;
    up_if.in_instr = b2b_instr[0];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b%0d_exec_ready", k), {31'd0, up_if.in_ready}, 32'd0);
      if (k < 2) up_if.in_instr = b2b_instr[k+1];
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b%0d_wb_ready", k), {31'd0, up_if.in_ready}, 32'd0);
      chk($sformatf("b2b%0d_wb_done", k),  {31'd0, up_if.done},     32'd1);
      chk($sformatf("b2b%0d_result", k),   {24'd0, up_if.done_result}, {24'd0, b2b_res[k]});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b%0d_idle_ready", k), {31'd0, up_if.in_ready}, 32'd1);
      chk($sformatf("b2b%0d_idle_done", k),  {31'd0, up_if.done},     32'd0);
      if (k == 2) up_if.in_valid = 1'b0;
    end
    rd_chk("b2b_r0", 2'd0, 8'h01);
    rd_chk("b2b_r1", 2'd1, 8'h02);
    rd_chk("b2b_r3", 2'd3, 8'hFF);
    flag_chk("b2b", 1'b0, 1'b0);

    // Remaining ops: r0=01 r1=02 r2=FF r3=FF.
    run_instr("dec", {4'b0100, 2'd2, 2'd0}, 8'hFE, 1'b0);
    run_instr("sr",  {4'b0111, 2'd2, 2'd0}, 8'h7F, 1'b0);
    run_instr("and", {4'b1000, 2'd2, 2'd1}, 8'h02, 1'b0);
    run_instr("not", {4'b1010, 2'd0, 2'd0}, 8'hFE, 1'b0);
    rd_chk("ops_r2", 2'd2, 8'h02);
    rd_chk("ops_r0", 2'd0, 8'hFE);
    flag_chk("ops", 1'b0, 1'b0);

    // Same-cycle host write r1=0F with accept of XOR r1,r1; host write in EXEC dropped.
    host_wr_en     = 1'b1;
    host_wr_addr   = 2'd1;
    host_wr_data   = 8'h0F;
    up_if.in_valid = 1'b1;
    up_if.in_instr = {4'b1100, 2'd1, 2'd1};
    @(posedge clk);
    @(negedge clk);
    up_if.in_valid = 1'b0;
    host_wr_addr   = 2'd0;
    host_wr_data   = 8'h55;
    @(posedge clk);
    @(negedge clk);
    host_wr_en = 1'b0;
    chk("xor_done",   {31'd0, up_if.done},        32'd1);
    chk("xor_result", {24'd0, up_if.done_result}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rd_chk("xor_r1", 2'd1, 8'h00);
    rd_chk("xor_r0_dropped", 2'd0, 8'hFE);
    flag_chk("xor", 1'b0, 1'b1);

    // Reset asserted during EXEC of INC r0 aborts the operation.
    up_if.in_valid = 1'b1;
    up_if.in_instr = {4'b0010, 2'd0, 2'd0};
    @(posedge clk);
    @(negedge clk);
    up_if.in_valid = 1'b0;
    chk("mid_exec_ready", {31'd0, up_if.in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready",  {31'd0, up_if.in_ready},   32'd1);
    chk("mid_rst_done",   {31'd0, up_if.done},       32'd0);
    chk("mid_rst_result", {24'd0, up_if.done_result}, 32'd0);
    flag_chk("mid_rst", 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rd_chk("mid_rst_r0", 2'd0, 8'h00);
    rd_chk("mid_rst_r2", 2'd2, 8'h00);
    rd_chk("mid_rst_r3", 2'd3, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_done",  {31'd0, up_if.done},     32'd0);
    chk("post_rst_ready", {31'd0, up_if.in_ready}, 32'd1);
    rd_chk("post_rst_r0", 2'd0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
